watch_set_controller: RTL and testbench
=======================================

Name: watch_set_controller

Overview:
- Sequences the watch time-of-day datapath: owns run/stop state, clear, and a time-setting mode with per-field adjustment.
- Converts debounced button levels and pulses into single-cycle setting ticks, including auto-repeat while a button is held.
- Returns to run mode when setting completes or times out.
- Sits between the button debouncers and the watch datapath's tick counters; also drives the blink/field outputs for the display layer.

Parameters:
- CLK_HZ, 100_000_000, clk frequency; ms strobe period = CLK_HZ/1000 cycles.
- REPEAT_DELAY_MS, 500, hold time from initial tick to first auto-repeat tick.
- REPEAT_RATE_MS, 100, interval between subsequent auto-repeat ticks.
- TIMEOUT_S, 10, idle time in a setting state before forced return to RUN.
- BLINK_HZ, 2, blink frequency of the selected field, 50% duty.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- i_set_req  in  1  one-cycle pulse: enter setting mode / advance to next field
- i_btn_up  in  1  debounced level, increment selected field
- i_btn_down  in  1  debounced level, decrement selected field
- i_run_stop  in  1  one-cycle pulse, toggles run flag
- i_clear  in  1  one-cycle pulse, clear request
- o_run  out  1  datapath run enable
- o_mode  out  1  count direction: 1 = down; valid with setting ticks
- o_clear  out  1  one-cycle clear pulse to datapath
- o_hour_tick  out  1  one-cycle setting tick, hour counter
- o_min_tick  out  1  one-cycle setting tick, min counter
- o_sec_tick  out  1  one-cycle setting tick, sec counter
- o_setting  out  1  high in any SET_* state
- o_field  out  2  0 = none, 1 = hour, 2 = min, 3 = sec
- o_blink  out  1  display enable for the selected field

Behaviour:
- All outputs are registered.
- Reset values: state RUN, run_flag 0, o_run 0, o_mode 0, o_clear 0, all ticks 0, o_setting 0, o_field 0, o_blink 1.
- Reset mid-operation aborts setting immediately. No ticks are emitted after reset asserts.
- States and transitions:
  - RUN -> SET_HOUR on i_set_req.
  - SET_HOUR -> SET_MIN -> SET_SEC -> RUN, each on i_set_req.
  - Any SET_* -> RUN on timeout.
- Run flag:
  - o_run = run_flag and (state == RUN).
  - i_run_stop toggles run_flag in RUN only; it is ignored in SET_* states.
  - run_flag is preserved across setting, so the clock resumes only if it was running before.
- Clear:
  - i_clear in RUN with run_flag = 0 -> o_clear high for exactly one cycle, on the next edge.
  - i_clear is otherwise ignored.
- Button edge detection:
  - Up-only rising edge sampled at edge k in a SET_* state -> selected-field tick high for one cycle after edge k, with o_mode = 0.
  - Down-only rising edge -> same, with o_mode = 1.
  - Exactly one tick output is high at a time. o_mode is 0 whenever no tick is asserted.
- Auto-repeat:
  - Uses a free-running ms strobe.
  - While the same single button stays held, the first repeat tick comes REPEAT_DELAY_MS strobes after the initial tick, then one every REPEAT_RATE_MS strobes.
  - Tolerance is ±1 strobe at real rates; timing is exact when CLK_HZ = 1000.
- Conflicts:
  - Both buttons high: no ticks, and the repeat counter is held at 0.
  - Release of either button cancels the repeat. A later single-button press counts as a fresh edge.
  - Button activity in RUN produces no ticks.
- Timeout:
  - A seconds counter restarts on entry to a SET_* state, on every i_set_req, and on every emitted tick.
  - Reaching TIMEOUT_S forces RUN.
  - i_set_req in the same cycle as timeout: i_set_req wins and the state advances.
- Same cycle as i_set_req:
  - A simultaneous button edge produces no tick and resets the repeat counter.
  - A pending repeat tick is suppressed.
- Blink:
  - o_blink toggles every CLK_HZ/(2*BLINK_HZ) cycles in SET_* states.
  - Forced to 1 on state entry and while any button is held. Always 1 in RUN.
- Outputs per state:
  - o_setting and o_field are derived from state.
  - o_field = 0 in RUN.

Decomposition:
- Shared package (watch_pkg) holds:
  - State encoding: RUN = 2'd0, SET_HOUR = 2'd1, SET_MIN = 2'd2, SET_SEC = 2'd3. The state encoding equals the o_field code.
  - Field code constants.
  - MS_DIV = CLK_HZ/1000 derivation.
- One sub-module, ms_strobe_gen: free-running one-cycle strobe every MS_DIV cycles, parameter CLK_HZ. It feeds the repeat, timeout and blink counters.

Test Plan (CLK_HZ = 1000, REPEAT_DELAY_MS = 5, REPEAT_RATE_MS = 2, TIMEOUT_S = 1, BLINK_HZ = 100):
- Reset, then i_run_stop pulse -> o_run = 1 next cycle. Second pulse -> o_run = 0. Then i_clear -> o_clear high exactly 1 cycle; i_clear while running -> no o_clear.
- Running, i_set_req -> o_setting = 1, o_field = 1, o_run = 0. Three more i_set_req -> fields 2, 3, then RUN with o_run = 1 restored.
- In SET_MIN, i_btn_down rises at cycle 0 and is held 12 cycles -> o_min_tick at cycles 1, 6, 8, 10, 12 with o_mode = 1 on each; no hour/sec ticks.
- In SET_HOUR, both buttons held 20 cycles -> zero ticks. Release up -> zero ticks until down is re-pressed.
- In SET_SEC, idle 1000 cycles -> state RUN, o_field = 0. Idle run with a tick at cycle 500 -> still SET_SEC at cycle 1000.
- rst asserted mid-repeat in SET_MIN -> ticks stop immediately; all outputs at their reset values before the next edge.

Source files
------------

// File: rtl/watch_pkg.sv
// Shared types and constants for the watch setting controller.
// State codes double as display field codes.
package watch_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } state_e;

  localparam logic [1:0] FIELD_NONE = 2'd0;
  localparam logic [1:0] FIELD_HOUR = 2'd1;
  localparam logic [1:0] FIELD_MIN  = 2'd2;
  localparam logic [1:0] FIELD_SEC  = 2'd3;

  function automatic int ms_div(input int clk_hz);
    return (clk_hz / 1000 < 1) ? 1 : clk_hz / 1000;
  endfunction

endpackage

// File: rtl/ms_strobe_gen.sv
// Free-running one-cycle strobe, once per millisecond of clk.
module ms_strobe_gen
  import watch_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic o_stb
);

  localparam int DIV = ms_div(CLK_HZ);
  localparam int W   = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt_q, cnt_d;
  logic         stb_q, stb_d;
  logic         wrap;

  always_comb begin
    wrap  = (cnt_q == W'(DIV - 1));
    cnt_d = wrap ? '0 : cnt_q + W'(1);
    stb_d = wrap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      stb_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      stb_q <= stb_d;
    end
  end

  assign o_stb = stb_q;

endmodule

// File: rtl/watch_set_controller.sv
// Run/stop, clear and field-setting sequencer for the watch datapath,
// with button auto-repeat, idle timeout and field blink.
module watch_set_controller
  import watch_pkg::*;
#(
  parameter int CLK_HZ          = 100_000_000,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100,
  parameter int TIMEOUT_S       = 10,
  parameter int BLINK_HZ        = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_set_req,
  input  logic       i_btn_up,
  input  logic       i_btn_down,
  input  logic       i_run_stop,
  input  logic       i_clear,
  output logic       o_run,
  output logic       o_mode,
  output logic       o_clear,
  output logic       o_hour_tick,
  output logic       o_min_tick,
  output logic       o_sec_tick,
  output logic       o_setting,
  output logic [1:0] o_field,
  output logic       o_blink
);

  localparam int TO_MS   = TIMEOUT_S * 1000;
  localparam int TO_W    = $clog2(TO_MS + 1);
  localparam int REP_MAX = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ?
                           REPEAT_DELAY_MS : REPEAT_RATE_MS;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam int BL_MS   = (1000 / (2 * BLINK_HZ) < 1) ?
                           1 : 1000 / (2 * BLINK_HZ);
  localparam int BL_W    = $clog2(BL_MS + 1);

  logic stb;

  ms_strobe_gen #(.CLK_HZ(CLK_HZ)) u_ms (
    .clk   (clk),
    .rst   (rst),
    .o_stb (stb)
  );

  state_e           state_q, state_d;
  logic             run_flag_q, run_flag_d;
  logic             up_q, up_d, dn_q, dn_d;
  logic             rep_act_q, rep_act_d;
  logic             rep_first_q, rep_first_d;
  logic             rep_dir_q, rep_dir_d;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [BL_W-1:0]  bl_cnt_q, bl_cnt_d;
  logic             run_q, run_d, mode_q, mode_d, clr_q, clr_d;
  logic             hour_q, hour_d, min_q, min_d, sec_q, sec_d;
  logic             set_q, set_d, blink_q, blink_d;
  logic [1:0]       field_q, field_d;

  logic             setting, up_edge, dn_edge, rep_hold;
  logic             tick, tick_dir, to_hit, entry;
  logic [REP_W-1:0] rep_tgt;

  always_comb begin
    state_d     = state_q;
    run_flag_d  = run_flag_q;
    up_d        = i_btn_up;
    dn_d        = i_btn_down;
    rep_act_d   = rep_act_q;
    rep_first_d = rep_first_q;
    rep_dir_d   = rep_dir_q;
    rep_cnt_d   = rep_cnt_q;
    to_cnt_d    = to_cnt_q;
    bl_cnt_d    = bl_cnt_q;
    blink_d     = blink_q;
    tick        = 1'b0;
    tick_dir    = 1'b0;

    setting  = (state_q != RUN);
    up_edge  = i_btn_up & ~up_q & ~i_btn_down;
    dn_edge  = i_btn_down & ~dn_q & ~i_btn_up;
    rep_hold = rep_dir_q ? (i_btn_down & ~i_btn_up)
                         : (i_btn_up & ~i_btn_down);
    rep_tgt  = rep_first_q ? REP_W'(REPEAT_DELAY_MS)
                           : REP_W'(REPEAT_RATE_MS);

    if (!setting || i_set_req) begin
      rep_act_d = 1'b0;
      rep_cnt_d = '0;
    end else if (up_edge || dn_edge) begin
      tick        = 1'b1;
      tick_dir    = dn_edge;
      rep_act_d   = 1'b1;
      rep_first_d = 1'b1;
      rep_dir_d   = dn_edge;
      rep_cnt_d   = '0;
    end else if (rep_act_q && rep_hold) begin
      if (stb) begin
        if (rep_cnt_q + REP_W'(1) == rep_tgt) begin
          tick        = 1'b1;
          tick_dir    = rep_dir_q;
          rep_cnt_d   = '0;
          rep_first_d = 1'b0;
        end else begin
          rep_cnt_d = rep_cnt_q + REP_W'(1);
        end
      end
    end else begin
      rep_act_d = 1'b0;
      rep_cnt_d = '0;
    end

    // Idle timer restarts on any operator activity.
    to_hit = setting & stb & ~tick & (to_cnt_q == TO_W'(TO_MS - 1));
    if (!setting || i_set_req || tick) begin
      to_cnt_d = '0;
    end else if (stb) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end

    if (i_set_req) begin
      unique case (state_q)
        RUN:      state_d = SET_HOUR;
        SET_HOUR: state_d = SET_MIN;
        SET_MIN:  state_d = SET_SEC;
        SET_SEC:  state_d = RUN;
        default:  state_d = RUN;
      endcase
    end else if (to_hit) begin
      state_d = RUN;
    end

    if (i_run_stop && state_q == RUN) begin
      run_flag_d = ~run_flag_q;
    end

    entry = (state_d != state_q);
    if (state_d == RUN || entry || i_btn_up || i_btn_down) begin
      blink_d  = 1'b1;
      bl_cnt_d = '0;
    end else if (stb) begin
      if (bl_cnt_q == BL_W'(BL_MS - 1)) begin
        bl_cnt_d = '0;
        blink_d  = ~blink_q;
      end else begin
        bl_cnt_d = bl_cnt_q + BL_W'(1);
      end
    end

    run_d   = run_flag_d & (state_d == RUN);
    clr_d   = i_clear & (state_q == RUN) & ~run_flag_q;
    mode_d  = tick & tick_dir;
    hour_d  = tick & (state_q == SET_HOUR);
    min_d   = tick & (state_q == SET_MIN);
    sec_d   = tick & (state_q == SET_SEC);
    set_d   = (state_d != RUN);
    field_d = state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      run_flag_q  <= 1'b0;
      up_q        <= 1'b0;
      dn_q        <= 1'b0;
      rep_act_q   <= 1'b0;
      rep_first_q <= 1'b0;
      rep_dir_q   <= 1'b0;
      rep_cnt_q   <= '0;
      to_cnt_q    <= '0;
      bl_cnt_q    <= '0;
      run_q       <= 1'b0;
      mode_q      <= 1'b0;
      clr_q       <= 1'b0;
      hour_q      <= 1'b0;
      min_q       <= 1'b0;
      sec_q       <= 1'b0;
      set_q       <= 1'b0;
      field_q     <= FIELD_NONE;
      blink_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      run_flag_q  <= run_flag_d;
      up_q        <= up_d;
      dn_q        <= dn_d;
      rep_act_q   <= rep_act_d;
      rep_first_q <= rep_first_d;
      rep_dir_q   <= rep_dir_d;
      rep_cnt_q   <= rep_cnt_d;
      to_cnt_q    <= to_cnt_d;
      bl_cnt_q    <= bl_cnt_d;
      run_q       <= run_d;
      mode_q      <= mode_d;
      clr_q       <= clr_d;
      hour_q      <= hour_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      set_q       <= set_d;
      field_q     <= field_d;
      blink_q     <= blink_d;
    end
  end

  assign o_run       = run_q;
  assign o_mode      = mode_q;
  assign o_clear     = clr_q;
  assign o_hour_tick = hour_q;
  assign o_min_tick  = min_q;
  assign o_sec_tick  = sec_q;
  assign o_setting   = set_q;
  assign o_field     = field_q;
  assign o_blink     = blink_q;

endmodule

// File: tb/tb_watch_set_controller.sv
// Scoreboard bench for watch_set_controller at CLK_HZ = 1000,
// where one ms strobe equals one clock.
module tb_watch_set_controller;

  logic       clk, rst;
  logic       i_set_req, i_btn_up, i_btn_down, i_run_stop, i_clear;
  logic       o_run, o_mode, o_clear;
  logic       o_hour_tick, o_min_tick, o_sec_tick;
  logic       o_setting, o_blink;
  logic [1:0] o_field;
  logic [2:0] ticks;

  typedef struct {
    int         cyc;
    logic [2:0] t;
    logic       m;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  assign ticks = {o_hour_tick, o_min_tick, o_sec_tick};

  watch_set_controller #(
    .CLK_HZ          (1000),
    .REPEAT_DELAY_MS (5),
    .REPEAT_RATE_MS  (2),
    .TIMEOUT_S       (1),
    .BLINK_HZ        (100)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_set_req   (i_set_req),
    .i_btn_up    (i_btn_up),
    .i_btn_down  (i_btn_down),
    .i_run_stop  (i_run_stop),
    .i_clear     (i_clear),
    .o_run       (o_run),
    .o_mode      (o_mode),
    .o_clear     (o_clear),
    .o_hour_tick (o_hour_tick),
    .o_min_tick  (o_min_tick),
    .o_sec_tick  (o_sec_tick),
    .o_setting   (o_setting),
    .o_field     (o_field),
    .o_blink     (o_blink)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic press_set(input int n);
    for (int i = 0; i < n; i++) begin
      i_set_req = 1'b1;
      step();
      i_set_req = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    {i_set_req, i_btn_up, i_btn_down, i_run_stop, i_clear} = '0;
    #1;
    checks++;
    if ({o_run, o_mode, o_clear, ticks, o_setting, o_field, o_blink}
        !== 10'b0000000001) begin
      failures++;
      $display("FAIL reset_async got=%b want=0000000001",
               {o_run, o_mode, o_clear, ticks, o_setting, o_field, o_blink});
    end
    step();
    step();
    rst = 1'b0;
    step();
    checks++;
    if ({o_run, o_mode, o_clear, ticks, o_setting, o_field, o_blink}
        !== 10'b0000000001) begin
      failures++;
      $display("FAIL reset_idle got=%b want=0000000001",
               {o_run, o_mode, o_clear, ticks, o_setting, o_field, o_blink});
    end
  endtask

  task automatic test_run_clear();
    i_run_stop = 1'b1; step(); i_run_stop = 1'b0;
    checks++;
    if (o_run !== 1'b1) begin
      failures++; $display("FAIL run_on got=%b want=1", o_run);
    end
    i_run_stop = 1'b1; step(); i_run_stop = 1'b0;
    checks++;
    if (o_run !== 1'b0) begin
      failures++; $display("FAIL run_off got=%b want=0", o_run);
    end
    i_clear = 1'b1; step(); i_clear = 1'b0;
    checks++;
    if (o_clear !== 1'b1) begin
      failures++; $display("FAIL clear_pulse got=%b want=1", o_clear);
    end
    step();
    checks++;
    if (o_clear !== 1'b0) begin
      failures++; $display("FAIL clear_one_cycle got=%b want=0", o_clear);
    end
    i_run_stop = 1'b1; step(); i_run_stop = 1'b0;
    i_clear = 1'b1; step(); i_clear = 1'b0;
    checks++;
    if (o_clear !== 1'b0 || o_run !== 1'b1) begin
      failures++;
      $display("FAIL clear_running clr=%b run=%b want clr=0 run=1",
               o_clear, o_run);
    end
  endtask

  task automatic test_set_cycle();
    bit seen0;
    press_set(1);
    checks++;
    if ({o_setting, o_field, o_run, o_blink} !== 5'b10101) begin
      failures++;
      $display("FAIL enter_hour got=%b want=10101",
               {o_setting, o_field, o_run, o_blink});
    end
    seen0 = 1'b0;
    for (int k = 0; k < 10 && !seen0; k++) begin
      step();
      if (o_blink === 1'b0) seen0 = 1'b1;
    end
    checks++;
    if (!seen0) begin
      failures++; $display("FAIL blink_toggle got=stuck1 want=toggle");
    end
    press_set(1);
    checks++;
    if ({o_setting, o_field} !== 3'b110) begin
      failures++; $display("FAIL field_min got=%b want=110", {o_setting, o_field});
    end
    press_set(1);
    checks++;
    if ({o_setting, o_field} !== 3'b111) begin
      failures++; $display("FAIL field_sec got=%b want=111", {o_setting, o_field});
    end
    press_set(1);
    checks++;
    if ({o_setting, o_field, o_run} !== 4'b0001) begin
      failures++;
      $display("FAIL back_run got=%b want=0001", {o_setting, o_field, o_run});
    end
  endtask

  task automatic test_repeat();
    int   base;
    exp_t e;
    int   dlist[5] = '{1, 6, 8, 10, 12};
    press_set(2);
    foreach (dlist[i]) exp_q.push_back('{dlist[i], 3'b010, 1'b1});
    i_btn_down = 1'b1;
    base = cyc;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 12) i_btn_down = 1'b0;
      checks++;
      if (ticks !== 3'b000) begin
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL repeat_extra cyc=%0d ticks=%b want=none", cyc - base, ticks);
        end else begin
          e = exp_q.pop_front();
          if (cyc - base != e.cyc || ticks !== e.t || o_mode !== e.m) begin
            failures++;
            $display("FAIL repeat_tick cyc=%0d t=%b m=%b want cyc=%0d t=%b m=%b",
                     cyc - base, ticks, o_mode, e.cyc, e.t, e.m);
          end
        end
      end else if (o_mode !== 1'b0) begin
        failures++; $display("FAIL mode_idle got=%b want=0", o_mode);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL repeat_missing got=%0d_left want=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_conflict();
    int   base;
    exp_t e;
    press_set(3);
    i_btn_up = 1'b1; i_btn_down = 1'b1;
    for (int k = 0; k < 30; k++) begin
      step();
      if (k == 19) i_btn_up = 1'b0;
      checks++;
      if (ticks !== 3'b000) begin
        failures++; $display("FAIL conflict_tick k=%0d got=%b want=000", k, ticks);
      end
    end
    i_btn_down = 1'b0;
    step();
    exp_q.push_back('{1, 3'b100, 1'b1});
    i_btn_down = 1'b1;
    base = cyc;
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++;
      if (ticks !== 3'b000) begin
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL repress_extra got=%b want=none", ticks);
        end else begin
          e = exp_q.pop_front();
          if (cyc - base != e.cyc || ticks !== e.t || o_mode !== e.m) begin
            failures++;
            $display("FAIL repress_tick cyc=%0d t=%b m=%b want cyc=%0d t=%b m=%b",
                     cyc - base, ticks, o_mode, e.cyc, e.t, e.m);
          end
        end
      end
    end
    i_btn_down = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL repress_missing got=%0d_left want=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_timeout();
    int   base;
    exp_t e;
    press_set(2);
    for (int k = 2; k <= 1006; k++) begin
      step();
      if (k == 995) begin
        checks++;
        if ({o_setting, o_field} !== 3'b111) begin
          failures++; $display("FAIL to_early got=%b want=111", {o_setting, o_field});
        end
      end
      if (k == 1006) begin
        checks++;
        if ({o_setting, o_field} !== 3'b000) begin
          failures++; $display("FAIL to_expire got=%b want=000", {o_setting, o_field});
        end
      end
    end
    press_set(3);
    base = cyc - 1;
    for (int k = 2; k <= 1520; k++) begin
      if (k == 500) begin
        i_btn_up = 1'b1;
        exp_q.push_back('{500, 3'b001, 1'b0});
      end
      step();
      i_btn_up = 1'b0;
      if (ticks !== 3'b000) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL to_extra got=%b want=none", ticks);
        end else begin
          e = exp_q.pop_front();
          if (cyc - base != e.cyc || ticks !== e.t || o_mode !== e.m) begin
            failures++;
            $display("FAIL to_tick cyc=%0d t=%b m=%b want cyc=%0d t=%b m=%b",
                     cyc - base, ticks, o_mode, e.cyc, e.t, e.m);
          end
        end
      end
      if (k == 1100) begin
        checks++;
        if ({o_setting, o_field} !== 3'b111) begin
          failures++; $display("FAIL to_restart got=%b want=111", {o_setting, o_field});
        end
      end
      if (k == 1520) begin
        checks++;
        if ({o_setting, o_field} !== 3'b000) begin
          failures++; $display("FAIL to_expire2 got=%b want=000", {o_setting, o_field});
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL to_missing got=%0d_left want=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    int   base;
    exp_t e;
    press_set(2);
    exp_q.push_back('{1, 3'b010, 1'b0});
    exp_q.push_back('{6, 3'b010, 1'b0});
    i_btn_up = 1'b1;
    base = cyc;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (ticks !== 3'b000) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL mid_extra got=%b want=none", ticks);
        end else begin
          e = exp_q.pop_front();
          if (cyc - base != e.cyc || ticks !== e.t || o_mode !== e.m) begin
            failures++;
            $display("FAIL mid_tick cyc=%0d t=%b m=%b want cyc=%0d t=%b m=%b",
                     cyc - base, ticks, o_mode, e.cyc, e.t, e.m);
          end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL mid_missing got=%0d_left want=0", exp_q.size());
      exp_q.delete();
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({o_run, o_mode, o_clear, ticks, o_setting, o_field, o_blink}
        !== 10'b0000000001) begin
      failures++;
      $display("FAIL mid_reset got=%b want=0000000001",
               {o_run, o_mode, o_clear, ticks, o_setting, o_field, o_blink});
    end
    step();
    rst = 1'b0;
    i_btn_up = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if (ticks !== 3'b000 || o_setting !== 1'b0) begin
        failures++;
        $display("FAIL post_reset t=%b set=%b want t=000 set=0", ticks, o_setting);
      end
    end
  endtask

  initial begin
    test_reset();
    test_run_clear();
    test_set_cycle();
    test_repeat();
    test_conflict();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
